mul_result_serializer: RTL and testbench
========================================

# mul_result_serializer

Downstream stage of the 8-bit array multiplier. Accepts one 16-bit product plus its overflow flag per transaction. Returns it over the 8-bit ALU result bus under valid/ready flow control: low byte first, then the high byte only when the overflow flag is set. Also keeps running counts of accepted products and overflowing products for status readback.

## Interface
- W, default 8: byte width. Product width is 2W.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  product presented
- in_ready  out  1  block can accept a product
- in_prod  in  2W  product from the multiplier
- in_ovf  in  1  multiplier overflow flag (high byte nonzero)
- out_valid  out  1  result byte valid
- out_ready  in  1  consumer accepts byte
- out_data  out  W  result byte
- out_hi  out  1  current byte is the high byte
- out_last  out  1  current byte is the final beat of the product
- cnt_clr  in  1  synchronous clear of both counters
- prod_cnt  out  W  accepted products, wraps modulo 2^W
- ovf_cnt  out  W  accepted products with in_ovf=1, saturates at 2^W-1

## Operation
- States:
  - S_IDLE: in_ready=1, out_valid=0.
  - S_LO: out_valid=1, out_data=prod_r[W-1:0], out_hi=0, out_last=~ovf_r.
  - S_HI: out_valid=1, out_data=prod_r[2W-1:W], out_hi=1, out_last=1.
- Accept = in_valid & in_ready. Accept only occurs in S_IDLE.
- On accept: capture prod_r and ovf_r, then go to S_LO.
- S_LO with out_ready=1: go to S_HI if ovf_r=1, else to S_IDLE.
- S_HI with out_ready=1: go to S_IDLE.
- Beat count follows in_ovf only. The block does not recompute overflow from in_prod. With in_ovf=1 and a zero high byte, it still sends two beats.
- in_prod and in_ovf are ignored outside S_IDLE.
- Counters:
  - prod_cnt increments on every accept and wraps.
  - ovf_cnt increments on accept with in_ovf=1 and holds at 2^W-1.
  - cnt_clr=1 forces both counters to 0 on the next edge. Clear wins over a same-cycle increment; that increment is lost.
- Reset: state S_IDLE, prod_r=0, ovf_r=0, both counters 0.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=0, out_hi=0, out_last=0.
  - Reset mid-transaction discards the product. out_valid drops asynchronously.

## Timing
- in_ready and all out_* signals decode combinationally from state and the capture registers. There are no combinational paths from in_* to out_*.
- Latency: accept at edge N gives out_valid=1 with the low byte from N+1.
- Throughput with out_ready held high:
  - no overflow: one product per 2 cycles;
  - overflow: one product per 3 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_hi and out_last are held stable.
- A beat completes on the edge where out_valid & out_ready.
- in_ready rises the cycle after the last beat completes. There is no same-cycle refill.
- Counters update on the accept edge and are visible the following cycle.

## Structure
- Shared package alu_pkg holds:
  - the state enum {S_IDLE, S_LO, S_HI};
  - the default byte width constant (8).
- One sub-module, sat_cnt: a W-bit counter with inc, clr (priority) and a saturate-enable parameter. It is instantiated twice: wrapping for prod_cnt, saturating for ovf_cnt.
- The FSM and capture registers live in the top module.

## Test plan
- No overflow: in_prod=0x0090, in_ovf=0, out_ready=1 → exactly one beat, out_data=0x90, out_hi=0, out_last=1. in_ready=1 again two cycles after accept.
- Overflow: in_prod=0xFE01, in_ovf=1 → beats 0x01 (out_hi=0, out_last=0) then 0xFE (out_hi=1, out_last=1). prod_cnt=1, ovf_cnt=1.
- Backpressure: hold out_ready=0 for 3 cycles during the 0xFE01 low beat → out_data stays 0x01 and out_valid stays 1. With in_valid held high, in_ready=0 and no second accept occurs.
- Flag/data mismatch: in_prod=0x0042, in_ovf=1 → two beats, 0x42 then 0x00 with out_last=1.
- Reset mid-transaction: assert rst_n=0 during the S_HI beat of 0xFE01 → out_valid=0 immediately, counters 0. After release: in_ready=1 and no stale beat.
- Counters: 256 accepts with in_ovf=1 → prod_cnt=0 (wrapped), ovf_cnt=255. Then cnt_clr=1 in the same cycle as an accept → both counters read 0 next cycle.

Source files
------------

// File: rtl/mul_result_serializer_pkg.sv
// Shared definitions for the multiplier result path: serializer FSM states
// and the default byte width.
package alu_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } ser_state_e;

endpackage : alu_pkg

// File: rtl/mul_result_serializer_sat_cnt.sv
// W-bit event counter with synchronous clear (clear beats increment) and an
// optional saturate-at-all-ones mode; otherwise it wraps.
module sat_cnt
  import alu_pkg::*;
#(
  parameter int unsigned W   = BYTE_W,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (SAT && (cnt_q == '1)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_cnt

// File: rtl/mul_result_serializer.sv
// Serializes a 2W-bit product onto a W-bit valid/ready bus: low byte, then the
// high byte only when the captured overflow flag is set. Tracks status counts.
module mul_result_serializer
  import alu_pkg::*;
#(
  parameter int unsigned W = BYTE_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_prod,
  input  logic           in_ovf,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_hi,
  output logic           out_last,
  input  logic           cnt_clr,
  output logic [W-1:0]   prod_cnt,
  output logic [W-1:0]   ovf_cnt
);

  ser_state_e     state_q, state_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic           ovf_q, ovf_d;
  logic           accept;

  // Outputs decode from state and capture registers only, never from in_*.
  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    ovf_d     = ovf_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_hi    = 1'b0;
    out_last  = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          prod_d  = in_prod;
          ovf_d   = in_ovf;
          state_d = S_LO;
        end
      end
      S_LO: begin
        out_valid = 1'b1;
        out_data  = prod_q[W-1:0];
        out_last  = ~ovf_q;
        if (out_ready) begin
          state_d = ovf_q ? S_HI : S_IDLE;
        end
      end
      S_HI: begin
        out_valid = 1'b1;
        out_data  = prod_q[2*W-1:W];
        out_hi    = 1'b1;
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

  sat_cnt #(
    .W   (W),
    .SAT (1'b0)
  ) u_prod_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (cnt_clr),
    .cnt   (prod_cnt)
  );

  sat_cnt #(
    .W   (W),
    .SAT (1'b1)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept & in_ovf),
    .clr   (cnt_clr),
    .cnt   (ovf_cnt)
  );

endmodule : mul_result_serializer

// File: tb/tb_mul_result_serializer.sv
// Directed bench for mul_result_serializer: vector table of single products
// plus hand-written reset, wrap/saturate and clear sequences.
module tb_mul_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_hi;
  logic        out_last;
  logic        cnt_clr;
  logic [7:0]  prod_cnt;
  logic [7:0]  ovf_cnt;

  int unsigned total;
  int unsigned bad;

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int unsigned stall;
    logic        hold;
    logic [7:0]  pc;
    logic [7:0]  oc;
  } vec_t;

  vec_t vecs[6];

  mul_result_serializer #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_hi    (out_hi),
    .out_last  (out_last),
    .cnt_clr   (cnt_clr),
    .prod_cnt  (prod_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One product through the block; in_prod/in_ovf are scrambled once busy.
  task automatic send(input vec_t v);
    logic exp_last_lo;
    exp_last_lo = !v.ovf;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
    in_valid  = 1'b1;
    in_prod   = v.prod;
    in_ovf    = v.ovf;
    out_ready = (v.stall == 0);
    @(negedge clk);
    in_valid = v.hold && (v.stall > 0);
    in_prod  = 16'h1234;
    in_ovf   = ~v.ovf;
    chk("lo_valid", out_valid, 1);
    chk("lo_data", out_data, v.prod[7:0]);
    chk("lo_hi", out_hi, 0);
    chk("lo_last", out_last, exp_last_lo);
    chk("prod_cnt", prod_cnt, v.pc);
    chk("ovf_cnt", ovf_cnt, v.oc);
    for (int unsigned i = 0; i < v.stall; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, v.prod[7:0]);
      chk("stall_last", out_last, exp_last_lo);
      chk("stall_in_ready", in_ready, 0);
      if (i == v.stall - 1) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
    end
    @(negedge clk);
    if (v.ovf) begin
      chk("hi_valid", out_valid, 1);
      chk("hi_data", out_data, v.prod[15:8]);
      chk("hi_hi", out_hi, 1);
      chk("hi_last", out_last, 1);
      @(negedge clk);
    end
    chk("done_valid", out_valid, 0);
    chk("done_ready", in_ready, 1);
    chk("done_prod_cnt", prod_cnt, v.pc);
    chk("done_ovf_cnt", ovf_cnt, v.oc);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tail;
    total = 0;
    bad   = 0;
    //          prod      ovf   stall hold  pc     oc
    vecs[0] = '{16'h0090, 1'b0, 0,    1'b0, 8'd1,  8'd0};
    vecs[1] = '{16'hFE01, 1'b1, 0,    1'b0, 8'd2,  8'd1};
    vecs[2] = '{16'hFE01, 1'b1, 3,    1'b1, 8'd3,  8'd2};
    vecs[3] = '{16'h0042, 1'b1, 0,    1'b0, 8'd4,  8'd3};
    vecs[4] = '{16'h00FF, 1'b0, 1,    1'b1, 8'd5,  8'd3};
    vecs[5] = '{16'h8000, 1'b1, 2,    1'b0, 8'd6,  8'd4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_ovf    = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_hi", out_hi, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_prod_cnt", prod_cnt, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i]);
    end

    // Reset asserted while the high beat of 0xFE01 is on the bus.
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = 16'hFE01;
    in_ovf   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_hi_data", out_data, 16'h00FE);
    chk("pre_rst_hi", out_hi, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_prod_cnt", prod_cnt, 0);
    chk("async_rst_ovf_cnt", ovf_cnt, 0);
    chk("async_rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    @(negedge clk);
    chk("post_rst_valid2", out_valid, 0);

    // 256 overflowing accepts: product count wraps, overflow count saturates.
    out_ready = 1'b1;
    in_prod   = 16'hABCD;
    in_ovf    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (i == 254) begin
        chk("cnt255_prod", prod_cnt, 8'd255);
        chk("cnt255_ovf", ovf_cnt, 8'd255);
      end
      @(negedge clk);
      @(negedge clk);
    end
    chk("wrap_prod_cnt", prod_cnt, 8'd0);
    chk("sat_ovf_cnt", ovf_cnt, 8'd255);

    // Clear coincident with an accept: the increment is lost.
    in_valid = 1'b1;
    cnt_clr  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    chk("clr_prod_cnt", prod_cnt, 8'd0);
    chk("clr_ovf_cnt", ovf_cnt, 8'd0);
    chk("clr_lo_data", out_data, 16'h00CD);
    @(negedge clk);
    chk("clr_hi_data", out_data, 16'h00AB);
    @(negedge clk);

    tail = '{16'hFE01, 1'b1, 0, 1'b0, 8'd1, 8'd1};
    send(tail);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mul_result_serializer
